div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 clock  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous active-high reset.
REQ-003 ctrl_DIV  input  1  start pulse; operands valid only in the cycle it is sampled high.
REQ-004 data_operandA  input  32  signed two's-complement dividend.
REQ-005 data_operandB  input  32  signed two's-complement divisor.
REQ-006 data_result  output  32  signed quotient, truncated toward zero.
REQ-007 data_remainder  output  32  signed remainder; its sign SHALL equal the dividend sign, or it SHALL be zero.
REQ-008 data_exception  output  1  divide-by-zero or overflow flag, valid while data_resultRDY is high.
REQ-009 data_resultRDY  output  1  one-cycle result-valid pulse.
REQ-010 busy  output  1  high from the load edge until the edge that raises data_resultRDY.

Function
REQ-011 States SHALL be IDLE, ITER, FIX and DONE; encoding is free.
REQ-012 Load edge (E0), ctrl_DIV sampled high in any state: latch |A| and |B| as 32-bit unsigned values, latch sign(A) and sign(B), clear the 64-bit remainder/quotient register RQ to {32'b0, |A|}, clear the 6-bit counter, clear the previous-MSB flag, and go to ITER.
REQ-013 E0 with B == 0: skip ITER and go to DONE at E0; at E1 data_result = 0, data_remainder = 0, data_exception = 1, data_resultRDY = 1.
REQ-014 Each ITER edge (E1..E32) SHALL perform one non-restoring step on RQ, as REQ-015 to REQ-017.
REQ-015 Step, part 1: RQ shifted left by 1; if prevMSB = 0, the upper 32 bits get |B| subtracted; if prevMSB = 1, |B| is added to them.
REQ-016 Step, part 2: RQ[0] = NOT(new RQ[63]); prevMSB is updated to the new RQ[63].
REQ-017 Step arithmetic SHALL be 32-bit modulo on the upper half, and the lower half SHALL take no carry from it.
REQ-018 The counter SHALL increment on each ITER edge; after the 32nd step (E32) the state SHALL move to FIX.
REQ-019 FIX edge (E33), part 1: if RQ[63] = 1, add |B| to the upper half (remainder correction).
REQ-020 FIX edge (E33), part 2: quotient = RQ[31:0], negated if sign(A) XOR sign(B); remainder negated if sign(A) = 1.
REQ-021 FIX edge (E33), part 3: register data_result and data_remainder, and go to DONE.
REQ-022 Overflow, A = 0x80000000 and B = 0xFFFFFFFF: data_result = 0x80000000, data_remainder = 0, data_exception = 1.
REQ-023 DONE (E33 to E34 for nonzero B): data_resultRDY = 1 for exactly one cycle, then the state returns to IDLE.
REQ-024 Latency for nonzero B SHALL be 34 edges from E0 to the data_resultRDY fall; data_resultRDY SHALL be high during the cycle after E33.
REQ-025 data_result, data_remainder and data_exception SHALL hold their values until the next result is registered.
REQ-026 ctrl_DIV high while busy SHALL abort the current operation with no data_resultRDY pulse and restart per REQ-012 with the new operands.
REQ-027 ctrl_DIV high in the DONE cycle SHALL still emit the pending data_resultRDY pulse and SHALL load the new operation on the same edge.
REQ-028 data_exception SHALL be 0 for every non-exceptional result.
REQ-029 Operand inputs SHALL be ignored on every edge except a load edge.

Reset
REQ-030 While reset is high: state = IDLE, RQ = 0, counter = 0, prevMSB = 0, data_result = 0, data_remainder = 0, data_exception = 0, data_resultRDY = 0, busy = 0.
REQ-031 Reset asserted mid-operation SHALL discard the operation with no data_resultRDY pulse.
REQ-032 The first ctrl_DIV sampled after reset deasserts SHALL start normally.

Verification
REQ-033 A = 100, B = 7 -> at E33: data_result = 14, data_remainder = 2, data_exception = 0, data_resultRDY high for 1 cycle, busy low afterward.
REQ-034 A = -100, B = 7 -> data_result = -14 (0xFFFFFFF2), data_remainder = -2 (0xFFFFFFFE); A = 100, B = -7 -> data_result = -14, data_remainder = 2.
REQ-035 A = 5, B = 0 -> at E1: data_result = 0, data_exception = 1, data_resultRDY pulse; no ITER cycles.
REQ-036 A = 0x80000000, B = 0xFFFFFFFF -> data_result = 0x80000000, data_exception = 1; A = 0x80000000, B = 1 -> data_result = 0x80000000, data_exception = 0.
REQ-037 Start 100/7, then pulse ctrl_DIV with 9/3 at E10 -> no pulse for 100/7; data_result = 3, data_remainder = 0 at E10 + 33.
REQ-038 Reset asserted at E20 of an operation -> all outputs 0 immediately; no data_resultRDY pulse; the next operation 49/7 returns 7 after 33 edges.

Source files
------------

// File: rtl/div_sequencer.sv
// Multi-cycle signed 32-bit divider built on a non-restoring shift/subtract core.
//
// A start pulse on ctrl_DIV latches the operand magnitudes and signs. The core then
// runs 32 iteration edges and one fix-up edge, and pulses data_resultRDY for one cycle.
// The quotient truncates toward zero. The remainder takes the sign of the dividend.
// A zero divisor skips the iterations and reports an exception on the next edge.
// A start pulse seen while busy abandons the current operation and starts the new one.
//
// Ports:
//   clock          - rising-edge clock
//   reset          - asynchronous active-high reset
//   ctrl_DIV       - start pulse; operands are sampled only on that edge
//   data_operandA  - signed dividend
//   data_operandB  - signed divisor
//   data_result    - signed quotient, held until the next result is registered
//   data_remainder - signed remainder, held until the next result is registered
//   data_exception - divide-by-zero or overflow (0x80000000 / -1)
//   data_resultRDY - one-cycle result-valid pulse
//   busy           - high from the load edge until the edge that raises data_resultRDY
module div_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic [31:0] data_remainder,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

  state_e      state_q;
  logic [63:0] rq_q;        // {partial remainder, dividend/quotient}
  logic [31:0] divisor_q;   // |B|
  logic        sign_a_q;
  logic        sign_b_q;
  logic [5:0]  count_q;
  logic        prev_msb_q;
  logic        div_zero_q;  // a zero-divisor result is still waiting to be posted
  logic        ovf_q;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] shifted_hi;
  logic [31:0] step_hi;
  logic [63:0] step_rq;
  logic [31:0] rem_mag;
  logic [31:0] quot_final;
  logic [31:0] rem_final;

  always_comb begin
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude
    abs_a = data_operandA[31] ? -data_operandA : data_operandA;
    abs_b = data_operandB[31] ? -data_operandB : data_operandB;

    // One non-restoring step. The upper half wraps modulo 2^32 and does not carry into the lower half.
    shifted_hi = {rq_q[62:32], rq_q[31]};
    step_hi    = prev_msb_q ? shifted_hi + divisor_q : shifted_hi - divisor_q;
    step_rq    = {step_hi, rq_q[30:0], ~step_hi[31]};

    // If the final partial remainder is negative, add the divisor back once
    rem_mag    = rq_q[63] ? rq_q[63:32] + divisor_q : rq_q[63:32];
    quot_final = (sign_a_q ^ sign_b_q) ? -rq_q[31:0] : rq_q[31:0];
    rem_final  = sign_a_q ? -rem_mag : rem_mag;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      rq_q           <= '0;
      divisor_q      <= '0;
      sign_a_q       <= 1'b0;
      sign_b_q       <= 1'b0;
      count_q        <= '0;
      prev_msb_q     <= 1'b0;
      div_zero_q     <= 1'b0;
      ovf_q          <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        // A load takes priority over everything, including aborting a running operation
        rq_q       <= {32'b0, abs_a};
        divisor_q  <= abs_b;
        sign_a_q   <= data_operandA[31];
        sign_b_q   <= data_operandB[31];
        count_q    <= '0;
        prev_msb_q <= 1'b0;
        ovf_q      <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        busy       <= 1'b1;
        if (data_operandB == 32'b0) begin
          div_zero_q <= 1'b1;
          state_q    <= StDone;
        end else begin
          div_zero_q <= 1'b0;
          state_q    <= StIter;
        end
      end else begin
        unique case (state_q)
          StIdle: ;
          StIter: begin
            rq_q       <= step_rq;
            prev_msb_q <= step_hi[31];
            count_q    <= count_q + 6'd1;
            if (count_q == 6'd31) state_q <= StFix;
          end
          StFix: begin
            rq_q           <= {rem_mag, rq_q[31:0]};
            data_result    <= quot_final;
            data_remainder <= rem_final;
            data_exception <= ovf_q;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state_q        <= StDone;
          end
          StDone: begin
            if (div_zero_q) begin
              data_result    <= '0;
              data_remainder <= '0;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
              busy           <= 1'b0;
              div_zero_q     <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

  logic        clock;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  div_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_remainder(data_remainder),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] rem;
    logic        exc;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] rem;
    logic        exc;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every result pulse must match the oldest expected entry
  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rdy: got pulse with result 0x%08h expected no pulse", data_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, data_result, e.res);
        check({e.name, "_remainder"}, data_remainder, e.rem);
        check({e.name, "_exception"}, {31'b0, data_exception}, {31'b0, e.exc});
      end
    end
  end

  // Call at a negedge; returns at the negedge just after the load edge
  task automatic launch(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [31:0] rem, input logic exc,
                        input bit push);
    exp_t e;
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    if (push) begin
      e.name = name; e.res = res; e.rem = rem; e.exc = exc;
      sb.push_back(e);
    end
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    // Operands are don't-care after the load edge
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Returns at the negedge where data_resultRDY is first seen high
  task automatic await_rdy(input string name, input int exp_lat);
    int lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no rdy within 60 edges expected rdy after %0d", name, exp_lat);
      sb.delete();
    end else begin
      check({name, "_latency"}, lat, exp_lat);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clock);
    launch(v.name, v.a, v.b, v.res, v.rem, v.exc, 1'b1);
    check({v.name, "_busy_hi"}, {31'b0, busy}, 32'd1);
    await_rdy(v.name, v.lat);
    check({v.name, "_busy_lo"}, {31'b0, busy}, 32'd0);
    @(negedge clock);
    check({v.name, "_rdy_fall"}, {31'b0, data_resultRDY}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{"p100_p7",   32'd100,          32'd7,          32'd14,         32'd2,          1'b0, 33},
      '{"n100_p7",   -32'sd100,        32'd7,          -32'sd14,       -32'sd2,        1'b0, 33},
      '{"p100_n7",   32'd100,          -32'sd7,        -32'sd14,       32'd2,          1'b0, 33},
      '{"n100_n7",   -32'sd100,        -32'sd7,        32'd14,         -32'sd2,        1'b0, 33},
      '{"div0",      32'd5,            32'd0,          32'd0,          32'd0,          1'b1, 1},
      '{"ovf",       32'h8000_0000,    32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b1, 33},
      '{"min_by_1",  32'h8000_0000,    32'd1,          32'h8000_0000,  32'd0,          1'b0, 33},
      '{"min_by_2",  32'h8000_0000,    32'd2,          32'hC000_0000,  32'd0,          1'b0, 33},
      '{"max_by_3",  32'h7FFF_FFFF,    32'd3,          32'd715827882,  32'd1,          1'b0, 33},
      '{"zero_by_5", 32'd0,            32'd5,          32'd0,          32'd0,          1'b0, 33},
      '{"p7_p100",   32'd7,            32'd100,        32'd0,          32'd7,          1'b0, 33},
      '{"n7_p100",   -32'sd7,          32'd100,        32'd0,          -32'sd7,        1'b0, 33},
      '{"big",       32'd123456789,    32'd10000,      32'd12345,      32'd6789,       1'b0, 33},
      '{"min_div0",  32'h8000_0000,    32'd0,          32'd0,          32'd0,          1'b1, 1},
      '{"p49_p7",    32'd49,           32'd7,          32'd7,          32'd0,          1'b0, 33}
    };

    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check("reset_result", data_result, 32'd0);
    check("reset_remainder", data_remainder, 32'd0);
    check("reset_flags", {29'b0, data_exception, data_resultRDY, busy}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort: 100/7 is replaced by 9/3 at E10 and must not produce its own pulse
    @(negedge clock);
    launch("abort_first", 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) @(negedge clock);
    launch("abort_9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
    await_rdy("abort_9_3", 33);
    @(negedge clock);
    check("abort_rdy_fall", {31'b0, data_resultRDY}, 32'd0);

    // Restart in the DONE cycle: pending pulse already out, new op loads on the same edge
    @(negedge clock);
    launch("done_first", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    await_rdy("done_first", 33);
    launch("done_second", -32'sd49, 32'd7, -32'sd7, 32'd0, 1'b0, 1'b1);
    check("done_rdy_fall", {31'b0, data_resultRDY}, 32'd0);
    check("done_busy", {31'b0, busy}, 32'd1);
    await_rdy("done_second", 33);

    // Reset at E20 clears everything at once and drops the operation
    @(negedge clock);
    launch("rst_first", 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (19) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_result", data_result, 32'd0);
    check("midrst_remainder", data_remainder, 32'd0);
    check("midrst_flags", {29'b0, data_exception, data_resultRDY, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    run_vec('{"after_rst", 32'd49, 32'd7, 32'd7, 32'd0, 1'b0, 33});

    repeat (40) @(negedge clock);
    check("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
